// File: rtl/axis_upsizer.sv
// AXI-Stream width upsizer: packs RATIO narrow beats into one wide beat with per-byte tkeep and tlast flush.
// Latency 1 cycle from the completing accept; s_axis_tready = !m_axis_tvalid | m_axis_tready. Build option: AXIS_UPSIZER_MSB_FIRST_EN.
module axis_upsizer #(
    parameter int IN_W  = 8,
    parameter int RATIO = 4,
    parameter int CNT_W = 32,
    localparam int OUT_W  = IN_W * RATIO,
    localparam int KEEP_W = OUT_W / 8,
    localparam int LANE_B = IN_W / 8,
    localparam int LW     = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [IN_W-1:0]   s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [OUT_W-1:0]  m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [CNT_W-1:0]  pkt_cnt
);

    logic [LW-1:0]     lane;
    logic [LW-1:0]     pos;
    logic [OUT_W-1:0]  acc_dat;
    logic [KEEP_W-1:0] acc_keep;
    logic [OUT_W-1:0]  acc_nxt_dat;
    logic [KEEP_W-1:0] acc_nxt_keep;
    logic              in_acc;
    logic              word_done;

    assign s_axis_tready = !m_axis_tvalid | m_axis_tready;
    assign in_acc        = s_axis_tvalid & s_axis_tready;
    assign word_done     = in_acc & ((lane == LW'(RATIO - 1)) | s_axis_tlast);

`ifdef AXIS_UPSIZER_MSB_FIRST_EN
    // Legacy ordering: the first beat of a word lands in the top lane.
    assign pos = LW'(RATIO - 1) - lane;
`else
    assign pos = lane;
`endif

    // Accumulator with the current input beat merged in.
    always_comb begin
        acc_nxt_dat  = acc_dat;
        acc_nxt_keep = acc_keep;
        for (int k = 0; k < RATIO; k++) begin
            if (pos == LW'(k)) begin
                acc_nxt_dat[k*IN_W +: IN_W]       = s_axis_tdata;
                acc_nxt_keep[k*LANE_B +: LANE_B]  = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane          <= '0;
            acc_dat       <= '0;
            acc_keep      <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            pkt_cnt       <= '0;
        end else begin
            if (word_done) begin
                m_axis_tdata  <= acc_nxt_dat;
                m_axis_tkeep  <= acc_nxt_keep;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= s_axis_tlast;
                lane          <= '0;
                // Cleared so unfilled lanes of the next partial word read as zero.
                acc_dat       <= '0;
                acc_keep      <= '0;
            end else begin
                if (in_acc) begin
                    lane     <= lane + 1'b1;
                    acc_dat  <= acc_nxt_dat;
                    acc_keep <= acc_nxt_keep;
                end
                if (m_axis_tvalid && m_axis_tready)
                    m_axis_tvalid <= 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
                pkt_cnt <= pkt_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_upsizer.sv
// Scoreboard bench for axis_upsizer: an 8x4 instance and a 16x2 instance, directed packets with hand-computed words.
module tb_axis_upsizer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  a_sd = '0;
    logic        a_sv = 1'b0, a_sl = 1'b0, a_srdy;
    logic [31:0] a_md;
    logic [3:0]  a_mk;
    logic        a_mv, a_ml, a_mrdy = 1'b1;
    logic [31:0] a_cnt;

    logic [15:0] b_sd = '0;
    logic        b_sv = 1'b0, b_sl = 1'b0, b_srdy;
    logic [31:0] b_md;
    logic [3:0]  b_mk;
    logic        b_mv, b_ml, b_mrdy = 1'b1;
    logic [31:0] b_cnt;

    axis_upsizer #(.IN_W(8), .RATIO(4), .CNT_W(32)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .s_axis_tdata(a_sd), .s_axis_tvalid(a_sv), .s_axis_tlast(a_sl), .s_axis_tready(a_srdy),
        .m_axis_tdata(a_md), .m_axis_tkeep(a_mk), .m_axis_tvalid(a_mv), .m_axis_tlast(a_ml),
        .m_axis_tready(a_mrdy), .pkt_cnt(a_cnt));

    axis_upsizer #(.IN_W(16), .RATIO(2), .CNT_W(32)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .s_axis_tdata(b_sd), .s_axis_tvalid(b_sv), .s_axis_tlast(b_sl), .s_axis_tready(b_srdy),
        .m_axis_tdata(b_md), .m_axis_tkeep(b_mk), .m_axis_tvalid(b_mv), .m_axis_tlast(b_ml),
        .m_axis_tready(b_mrdy), .pkt_cnt(b_cnt));

    int checks = 0;
    int errors = 0;

    logic [36:0] qa[$];
    logic [36:0] qb[$];

    // Expected words are written in LSB-first lane order; the legacy build mirrors the lanes.
    function automatic logic [36:0] ea(input logic [31:0] d, input logic [3:0] k, input logic l);
`ifdef AXIS_UPSIZER_MSB_FIRST_EN
        return {l, k[0], k[1], k[2], k[3], d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return {l, k, d};
`endif
    endfunction

    function automatic logic [36:0] eb(input logic [31:0] d, input logic [3:0] k, input logic l);
`ifdef AXIS_UPSIZER_MSB_FIRST_EN
        return {l, k[1:0], k[3:2], d[15:0], d[31:16]};
`else
        return {l, k, d};
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic send_a(input logic [7:0] d, input logic l);
        int n = 0;
        a_sd = d; a_sl = l; a_sv = 1'b1;
        @(negedge clk);
        while (!a_srdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_a_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        a_sv = 1'b0; a_sl = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] d, input logic l);
        int n = 0;
        b_sd = d; b_sl = l; b_sv = 1'b1;
        @(negedge clk);
        while (!b_srdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_b_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        b_sv = 1'b0; b_sl = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0 || a_mv || b_mv) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) chk("drain_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
    endtask

    // Monitor A: scoreboard pop on each transfer, plus hold/backpressure checks while stalled.
    logic [36:0] snap_a;
    logic        stall_prev = 1'b0;
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (a_mv && a_mrdy) begin
                if (qa.size() == 0) chk("a_unexpected_word", {27'd0, a_ml, a_mk, a_md}, 64'd0);
                else chk("a_word", {27'd0, a_ml, a_mk, a_md}, {27'd0, qa.pop_front()});
            end
            if (a_mv && !a_mrdy) begin
                chk("a_stall_s_ready_low", {63'd0, a_srdy}, 64'd0);
                if (stall_prev) chk("a_stall_hold", {27'd0, a_ml, a_mk, a_md}, {27'd0, snap_a});
                snap_a = {a_ml, a_mk, a_md};
            end
            stall_prev = a_mv && !a_mrdy;
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset_n && b_mv && b_mrdy) begin
            if (qb.size() == 0) chk("b_unexpected_word", {27'd0, b_ml, b_mk, b_md}, 64'd0);
            else chk("b_word", {27'd0, b_ml, b_mk, b_md}, {27'd0, qb.pop_front()});
        end
    end

    initial begin
        #2;
        chk("reset_a_outputs", {27'd0, a_ml, a_mk, a_md}, 64'd0);
        chk("reset_a_valid_cnt", {31'd0, a_mv, a_cnt}, 64'd0);
        chk("reset_s_ready", {63'd0, a_srdy}, 64'd1);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Full 4-byte packet, latency check right after the last accept.
        qa.push_back(ea(32'h44332211, 4'hF, 1'b1));
        send_a(8'h11, 1'b0);
        send_a(8'h22, 1'b0);
        send_a(8'h33, 1'b0);
        chk("a_valid_before_last", {63'd0, a_mv}, 64'd0);
        send_a(8'h44, 1'b1);
        chk("a_latency_valid", {63'd0, a_mv}, 64'd1);
        drain(20);
        chk("a_pkt_cnt_1", {32'd0, a_cnt}, 64'd1);

        // 6-byte packet: full word then a 2-lane flush.
        qa.push_back(ea(32'h04030201, 4'hF, 1'b0));
        qa.push_back(ea(32'h00000605, 4'h3, 1'b1));
        for (int i = 1; i <= 6; i++) send_a(8'(i), i == 6);
        drain(20);

        // Single-byte packet.
        qa.push_back(ea(32'h000000AB, 4'h1, 1'b1));
        send_a(8'hAB, 1'b1);
        drain(20);
        chk("a_pkt_cnt_3", {32'd0, a_cnt}, 64'd3);

        // 16 continuous bytes with a 5-cycle output stall after the first word.
        for (int w = 0; w < 4; w++) begin
            logic [7:0] b0;
            b0 = 8'h80 + 8'(4 * w);
            qa.push_back(ea({b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0}, 4'hF, w == 3));
        end
        fork
            for (int i = 0; i < 16; i++) send_a(8'h80 + 8'(i), i == 15);
            begin
                int n = 0;
                @(negedge clk);
                while (!a_mv && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 50) chk("a_first_word_timeout", 64'd1, 64'd0);
                @(posedge clk); #1;
                a_mrdy = 1'b0;
                repeat (5) @(posedge clk);
                #1 a_mrdy = 1'b1;
            end
        join
        drain(40);
        chk("a_pkt_cnt_4", {32'd0, a_cnt}, 64'd4);

        // Reset in the middle of a packet: the partial word must vanish.
        send_a(8'h55, 1'b0);
        send_a(8'h66, 1'b0);
        reset_n = 1'b0;
        #3;
        chk("midreset_a_outputs", {27'd0, a_ml, a_mk, a_md}, 64'd0);
        chk("midreset_a_valid_cnt", {31'd0, a_mv, a_cnt}, 64'd0);
        chk("midreset_b_cnt", {32'd0, b_cnt}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        qa.push_back(ea(32'hDDCCBBAA, 4'hF, 1'b1));
        send_a(8'hAA, 1'b0);
        send_a(8'hBB, 1'b0);
        send_a(8'hCC, 1'b0);
        send_a(8'hDD, 1'b1);
        drain(20);
        chk("a_pkt_cnt_after_reset", {32'd0, a_cnt}, 64'd1);

        // 16-bit lanes, ratio 2.
        qb.push_back(eb(32'h56781234, 4'hF, 1'b1));
        qb.push_back(eb(32'h00009ABC, 4'h3, 1'b1));
        send_b(16'h1234, 1'b0);
        send_b(16'h5678, 1'b1);
        send_b(16'h9ABC, 1'b1);
        drain(20);
        chk("b_pkt_cnt_2", {32'd0, b_cnt}, 64'd2);

        chk("a_queue_empty", 64'(qa.size()), 64'd0);
        chk("b_queue_empty", 64'(qb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
